div_share_ctrl: RTL
===================

// Module: div_share_ctrl
// PURPOSE
//  Sequencer/arbiter that shares one multicycle restoring divider between two requesters.
//  Round-robin grant, one quotient bit per clock, response held until the consumer accepts it.
//  Sits between requester ports and downstream logic that consumes quotient/remainder.
//  Replaces per-requester combinational dividers.
// PARAMETERS
//  WIDTH  4  operand width (dividend, divisor, quotient, remainder); unsigned; WIDTH>=2
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          synchronous, active-low reset
//  req_valid      in   2          per-requester request valid
//  req_ready      out  2          per-requester accept; one-hot or zero
//  req_dividend   in   2*WIDTH    requester i occupies bits [i*WIDTH +: WIDTH]
//  req_divisor    in   2*WIDTH    same packing as req_dividend
//  rsp_valid      out  1          result available
//  rsp_ready      in   1          consumer accepts result
//  rsp_id         out  1          index of the requester that owns the result
//  rsp_quotient   out  WIDTH      quotient
//  rsp_remainder  out  WIDTH      remainder
//  rsp_err        out  1          divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rsp_valid=0, rsp_id=0, rsp_quotient=0,
//    rsp_remainder=0, rsp_err=0, last_grant=1 (requester 0 wins first), cycle counter=0.
//  - Reset mid-operation aborts the division; the in-flight result is discarded, never emitted.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: grant = round-robin over req_valid.
//    - If only one requester is valid, grant it.
//    - If both are valid, grant the one != last_grant.
//    - req_ready[grant]=1 combinationally, only in IDLE.
//    - Transfer when req_valid[g]&req_ready[g]: latch operands, set rsp_id=g, last_grant=g,
//      Q=dividend, R=0 (WIDTH+1 bits), count=0, go to CALC.
//  - CALC: exactly WIDTH cycles.
//    - Each cycle: R' = {R[WIDTH-1:0], Q[WIDTH-1]}; T = R' - {1'b0,divisor} (WIDTH+1 bits).
//    - If T[WIDTH]==0: R=T, Q={Q[WIDTH-2:0],1}; else R=R', Q={Q[WIDTH-2:0],0}.
//    - After the WIDTH-th step go to DONE.
//  - DONE: rsp_valid=1 with rsp_quotient=Q, rsp_remainder=R[WIDTH-1:0]; outputs stable while
//    rsp_valid&!rsp_ready. On rsp_valid&rsp_ready: rsp_valid=0 next cycle, return to IDLE.
//  - Latency: handshake at cycle N -> rsp_valid first high at cycle N+WIDTH+1.
//  - Max throughput: one result per WIDTH+2 cycles (rsp_ready tied high).
//  - req_ready=0 in CALC/DONE; requests wait; no queueing. Operand changes on a waiting
//    (unaccepted) request are allowed.
//  - A requester re-asserting after service while the other waits loses arbitration (no starvation).
//  - Results are exact for all unsigned operands; quotient<=dividend; remainder<divisor when divisor!=0.
// CONFIGURATION
//  DIV_ZERO_CHK_EN defined:
//   - Accepted divisor==0 skips CALC: IDLE -> DONE directly.
//   - rsp_valid at cycle N+1 with rsp_quotient={WIDTH{1}}, rsp_remainder=dividend, rsp_err=1.
//   - rsp_err=0 for all divisor!=0 results.
//  DIV_ZERO_CHK_EN undefined:
//   - divisor==0 runs the normal WIDTH-cycle CALC (natural result: quotient all-ones,
//     remainder=dividend).
//   - rsp_err is tied 0.
// TESTING (WIDTH=4)
//  1. req0 13/3 at cycle N, rsp_ready=1 -> rsp_valid at N+5, id=0, q=4, r=1; back to IDLE at N+6.
//  2. req0 and req1 both valid (9/2, 15/1) from reset -> id=0 q=4 r=1 first, then id=1 q=15 r=0;
//     req1 not starved when req0 re-asserts.
//  3. 7/7 with rsp_ready=0 for 5 cycles after rsp_valid -> q=1 r=0 held stable, req_ready=0
//     throughout; single response on release.
//  4. 0/5 -> q=0 r=0; 15/15 -> q=1 r=0; 1/15 -> q=0 r=1.
//  5. 11/0 -> with DIV_ZERO_CHK_EN: rsp_valid at N+1, q=15 r=11 err=1;
//     without: rsp_valid at N+5, q=15 r=11 err=0.
//  6. rst_n=0 for one cycle during CALC of 12/5 -> no rsp_valid; all outputs 0; next request
//     goes to requester 0 first.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Shares one restoring divider between two requesters; round-robin grant, result WIDTH+1 cycles after accept,
// held until rsp_ready. Optional divide-by-zero short-cut and rsp_err flag under `DIV_ZERO_CHK_EN.
module div_share_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_dividend,
   input  logic [2*WIDTH-1:0] req_divisor,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_quotient,
   output logic [WIDTH-1:0]   rsp_remainder,
   output logic               rsp_err
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic             vld_q;
   logic             id_q;
   logic             last_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;

   logic             gnt;
   logic [WIDTH-1:0] dvd_sel;
   logic [WIDTH-1:0] dvs_sel;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      gnt       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      req_ready = 2'b00;
      if (state_q == IDLE && |req_valid) begin
         req_ready = gnt ? 2'b10 : 2'b01;
      end
      dvd_sel = gnt ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
      dvs_sel = gnt ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];
   end

   // The partial remainder is always below the divisor, so WIDTH bits of storage suffice.
   always_comb begin
      r_sh = {r_q, q_q[WIDTH-1]};
      t    = r_sh - {1'b0, dvs_q};
      r_d  = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
      q_d  = {q_q[WIDTH-2:0], ~t[WIDTH]};
   end

`ifdef DIV_ZERO_CHK_EN
   logic err_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         q_q     <= '0;
         r_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
`ifdef DIV_ZERO_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  id_q   <= gnt;
                  last_q <= gnt;
                  dvs_q  <= dvs_sel;
                  cnt_q  <= '0;
`ifdef DIV_ZERO_CHK_EN
                  if (dvs_sel == '0) begin
                     q_q     <= '1;
                     r_q     <= dvd_sel;
                     err_q   <= 1'b1;
                     vld_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     q_q     <= dvd_sel;
                     r_q     <= '0;
                     err_q   <= 1'b0;
                     state_q <= CALC;
                  end
`else
                  q_q     <= dvd_sel;
                  r_q     <= '0;
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid     = vld_q;
   assign rsp_id        = id_q;
   assign rsp_quotient  = q_q;
   assign rsp_remainder = r_q;
`ifdef DIV_ZERO_CHK_EN
   assign rsp_err       = err_q;
`else
   assign rsp_err       = 1'b0;
`endif

endmodule
